// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner: column scan, per-sample debounce, key decode, one-clk strobe per press.
// Optional auto-repeat while held is built only when KEYPAD_REPEAT_EN is defined.
module keypad_scanner #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_DELAY   = 100,
  parameter int REPEAT_RATE    = 25
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_SCANS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  // Indexed by {row, col}: 1 2 3 A / 4 5 6 B / 7 8 9 C / E 0 F D
  localparam logic [63:0] KEY_MAP = 64'hDF0E_C987_B654_A321;

  if (SCAN_DIV < 4)       $error("SCAN_DIV must be >= 4");
  if (DEBOUNCE_SCANS < 1) $error("DEBOUNCE_SCANS must be >= 1");
  if (REPEAT_DELAY < 1)   $error("REPEAT_DELAY must be >= 1");
  if (REPEAT_RATE < 1)    $error("REPEAT_RATE must be >= 1");

  typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED} state_t;

  state_t           state, state_nxt;
  logic [3:0]       row_meta, row_sync;
  logic [DIV_W-1:0] div;
  logic             sample;
  logic [1:0]       col_idx, col_nxt;
  logic [1:0]       lat_row, lat_row_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             hit;
  logic [1:0]       hit_row;
  logic             lat_low;
  logic             accept;
  logic             rep_fire;
  logic [3:0]       code_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta <= 4'hF;
      row_sync <= 4'hF;
      div      <= '0;
    end else begin
      row_meta <= row_in;
      row_sync <= row_meta;
      div      <= (div == DIV_LAST) ? '0 : div + DIV_W'(1);
    end
  end

  assign sample  = (div == DIV_LAST);
  assign lat_low = ~row_sync[lat_row];

  // Lowest row index wins when several rows are low in the driven column
  always_comb begin
    hit     = 1'b0;
    hit_row = 2'd0;
    for (int r = 3; r >= 0; r--) begin
      if (!row_sync[r]) begin
        hit     = 1'b1;
        hit_row = 2'(r);
      end
    end
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int REP_W = $clog2(((REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE) + 1);
  localparam logic [REP_W-1:0] REP_FIRST = REP_W'(REPEAT_DELAY);
  localparam logic [REP_W-1:0] REP_NEXT  = REP_W'(REPEAT_RATE);

  logic [REP_W-1:0] rep_cnt, rep_cnt_nxt;
  logic             rep_phase, rep_phase_nxt;

  // Low samples are counted only while PRESSED; any high sample restarts the repeat schedule
  always_comb begin
    rep_cnt_nxt   = rep_cnt;
    rep_phase_nxt = rep_phase;
    rep_fire      = 1'b0;
    if (state != PRESSED) begin
      rep_cnt_nxt   = '0;
      rep_phase_nxt = 1'b0;
    end else if (sample) begin
      if (!lat_low) begin
        rep_cnt_nxt   = '0;
        rep_phase_nxt = 1'b0;
      end else if (rep_cnt + REP_W'(1) == (rep_phase ? REP_NEXT : REP_FIRST)) begin
        rep_fire      = 1'b1;
        rep_cnt_nxt   = '0;
        rep_phase_nxt = 1'b1;
      end else begin
        rep_cnt_nxt   = rep_cnt + REP_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt   <= '0;
      rep_phase <= 1'b0;
    end else begin
      rep_cnt   <= rep_cnt_nxt;
      rep_phase <= rep_phase_nxt;
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SCAN;
      col_idx   <= 2'd0;
      lat_row   <= 2'd0;
      cnt       <= '0;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      col_idx   <= col_nxt;
      lat_row   <= lat_row_nxt;
      cnt       <= cnt_nxt;
      key_valid <= accept | rep_fire;
      if (accept)
        key_code <= code_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    col_nxt     = col_idx;
    lat_row_nxt = lat_row;
    cnt_nxt     = cnt;
    accept      = 1'b0;
    if (sample) begin
      case (state)
        SCAN: begin
          if (!hit) begin
            col_nxt = col_idx + 2'd1;
          end else begin
            lat_row_nxt = hit_row;
            if (DB_LAST == CNT_ONE) begin
              accept    = 1'b1;
              cnt_nxt   = '0;
              state_nxt = PRESSED;
            end else begin
              cnt_nxt   = CNT_ONE;
              state_nxt = DEBOUNCE;
            end
          end
        end
        DEBOUNCE: begin
          // A bounce returns to SCAN on the same column; rotation resumes on the next idle sample
          if (!lat_low) begin
            state_nxt = SCAN;
          end else if (cnt + CNT_ONE == DB_LAST) begin
            accept    = 1'b1;
            cnt_nxt   = '0;
            state_nxt = PRESSED;
          end else begin
            cnt_nxt   = cnt + CNT_ONE;
          end
        end
        PRESSED: begin
          if (lat_low) begin
            cnt_nxt = '0;
          end else if (cnt + CNT_ONE == DB_LAST) begin
            cnt_nxt   = '0;
            col_nxt   = col_idx + 2'd1;
            state_nxt = SCAN;
          end else begin
            cnt_nxt   = cnt + CNT_ONE;
          end
        end
        default: state_nxt = SCAN;
      endcase
    end
  end

  always_comb begin
    col_out  = ~(4'b0001 << col_idx);
    key_held = (state == PRESSED);
    code_nxt = KEY_MAP[{lat_row_nxt, col_idx, 2'b00} +: 4];
  end

endmodule
